// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared types and helpers for the convolution sequencer.
//   conv_seq_state_t  : sequencer states (LOAD, COMPUTE, DRAIN, OUTPUT)
//   conv_num_outputs  : number of outputs produced per input vector
// ---------------------------------------------------------------------------
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2,
    OUTPUT  = 2'd3
  } conv_seq_state_t;

  // Valid (no zero padding) convolution length.
  function automatic int conv_num_outputs(input int lenx, input int lenf);
    return lenx - lenf + 1;
  endfunction

endpackage

// File: rtl/conv_seq_addr_gen.sv
// ---------------------------------------------------------------------------
// conv_seq_addr_gen
// Output index (n) / tap index (k) counters and the one-cycle issue pipeline
// that lines acc_en/acc_clr up with data returning from the x memory and the
// filter ROM.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   clear_i        : load finished, restart at output 0
//   issue_i        : a read pair is issued this cycle (COMPUTE)
//   advance_i      : output accepted, move to the next output index
//   x_addr_o       : x memory read address n+k
//   f_addr_o       : filter ROM address k
//   last_tap_o     : k is on the final tap
//   last_out_o     : n is the final output of the vector
//   acc_en_o       : accumulate the data returned this cycle
//   acc_clr_o      : data returned this cycle belongs to tap 0
// ---------------------------------------------------------------------------
module conv_seq_addr_gen
  import conv_pkg::*;
#(
  parameter int LENX  = 20,
  parameter int LENF  = 13,
  parameter int ADDRX = $clog2(LENX),
  parameter int ADDRF = $clog2(LENF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             issue_i,
  input  logic             advance_i,
  output logic [ADDRX-1:0] x_addr_o,
  output logic [ADDRF-1:0] f_addr_o,
  output logic             last_tap_o,
  output logic             last_out_o,
  output logic             acc_en_o,
  output logic             acc_clr_o
);

  localparam int NOUT = conv_num_outputs(LENX, LENF);

  logic [ADDRX-1:0] n_q, n_d;
  logic [ADDRF-1:0] k_q, k_d;
  logic             acc_en_q, acc_clr_q;

  assign last_tap_o = (k_q == ADDRF'(LENF - 1));
  assign last_out_o = (n_q == ADDRX'(NOUT - 1));
  // n+k stays below LENX because n <= LENX-LENF and k <= LENF-1.
  assign x_addr_o   = n_q + ADDRX'(k_q);
  assign f_addr_o   = k_q;
  assign acc_en_o   = acc_en_q;
  assign acc_clr_o  = acc_clr_q;

  // Next-state logic for the tap and output counters.
  always_comb begin
    k_d = k_q;
    n_d = n_q;
    if (issue_i) begin
      if (last_tap_o) begin
        k_d = '0;
      end else begin
        k_d = k_q + ADDRF'(1);
      end
    end else begin
      k_d = k_q;
    end
    if (clear_i) begin
      n_d = '0;
    end else if (advance_i) begin
      n_d = n_q + ADDRX'(1);
    end else begin
      n_d = n_q;
    end
  end

  // Counter state and the issue-delay flops (memory/ROM read latency is one cycle).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q       <= '0;
      k_q       <= '0;
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
    end else begin
      n_q       <= n_d;
      k_q       <= k_d;
      acc_en_q  <= issue_i;
      acc_clr_q <= issue_i & (k_q == '0);
    end
  end

endmodule

// File: rtl/conv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// conv_seq_ctrl
// Sequencer for the convolution datapath: loads LENX samples into x memory,
// then for each of LENX-LENF+1 outputs issues LENF read pairs and presents the
// finished y with full back-pressure.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   s_valid_x / s_ready_x : input sample handshake
//   x_wr_en, x_addr       : x memory write enable, write/read address
//   f_addr                : filter ROM address
//   acc_en, acc_clr       : accumulator update / load-instead-of-add
//   m_valid_y / m_ready_y : output handshake
//   busy                  : not in LOAD
//   stall_cnt             : (CONV_SEQ_PERF_EN only) saturating count of
//                           cycles with m_valid_y & !m_ready_y
// Build option: define CONV_SEQ_PERF_EN to add the stall counter.
// ---------------------------------------------------------------------------
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int LENX  = 20,
  parameter int LENF  = 13,
  parameter int ADDRX = $clog2(LENX),
  parameter int ADDRF = $clog2(LENF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  output logic             x_wr_en,
  output logic [ADDRX-1:0] x_addr,
  output logic [ADDRF-1:0] f_addr,
  output logic             acc_en,
  output logic             acc_clr,
  output logic             m_valid_y,
  input  logic             m_ready_y,
  output logic             busy
`ifdef CONV_SEQ_PERF_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  if (LENF > LENX) begin : g_param_check
    $error("conv_seq_ctrl: LENF (%0d) must not exceed LENX (%0d)", LENF, LENX);
  end

  conv_seq_state_t  state_q;
  logic [ADDRX-1:0] wr_cnt_q;
  logic             m_valid_y_q;

  logic             load_done_s;
  logic             last_tap_s;
  logic             last_out_s;
  logic [ADDRX-1:0] rd_addr_s;

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign s_ready_x   = (state_q == LOAD) & ~reset;
  assign x_wr_en     = s_valid_x & s_ready_x;
  assign load_done_s = x_wr_en & (wr_cnt_q == ADDRX'(LENX - 1));
  assign x_addr      = (state_q == LOAD) ? wr_cnt_q : rd_addr_s;
  assign m_valid_y   = m_valid_y_q;
  assign busy        = (state_q != LOAD);

  conv_seq_addr_gen #(
    .LENX (LENX),
    .LENF (LENF),
    .ADDRX(ADDRX),
    .ADDRF(ADDRF)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (load_done_s),
    .issue_i   (state_q == COMPUTE),
    .advance_i ((state_q == OUTPUT) & m_ready_y & ~last_out_s),
    .x_addr_o  (rd_addr_s),
    .f_addr_o  (f_addr),
    .last_tap_o(last_tap_s),
    .last_out_o(last_out_s),
    .acc_en_o  (acc_en),
    .acc_clr_o (acc_clr)
  );

  // Sequencer FSM with load counter and registered m_valid_y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      wr_cnt_q    <= '0;
      m_valid_y_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (x_wr_en) begin
            if (load_done_s) begin
              wr_cnt_q <= '0;
              state_q  <= COMPUTE;
            end else begin
              wr_cnt_q <= wr_cnt_q + ADDRX'(1);
            end
          end
        end
        COMPUTE: begin
          if (last_tap_s) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Last accumulate lands this cycle; y is complete on the next.
          state_q     <= OUTPUT;
          m_valid_y_q <= 1'b1;
        end
        OUTPUT: begin
          if (m_ready_y) begin
            m_valid_y_q <= 1'b0;
            state_q     <= last_out_s ? LOAD : COMPUTE;
          end
        end
        default: begin
          state_q     <= LOAD;
          m_valid_y_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] stall_cnt_q;

  assign stall_cnt = stall_cnt_q;

  // Saturating count of cycles where y is offered but not taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else if (m_valid_y_q & ~m_ready_y & (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
`endif

endmodule
